// File: rtl/uart_receiver.sv
// uart_receiver: 8x-oversampled UART receive stage.
// Frame: 1 start bit, 8 data bits (LSB first), optional even parity, 1 stop bit.
// The received byte is presented in RDR, with RDRF, OE, FE and PE status flags.
// Define UART_RX_PARITY_EN to add the parity bit and a live PE flag;
// without it the frame has no parity bit and PE is tied low.

module uart_receiver (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       bclkx8,
    input  logic       rdrf_clr,
    output logic [7:0] RDR,
    output logic       RDRF,
    output logic       OE,
    output logic       FE,
    output logic       PE
);

    typedef enum logic [1:0] {
        IDLE,
        START_DET,
        RECV_DATA
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam logic [3:0] STOP_CT = 4'd9;
`else
    localparam logic [3:0] STOP_CT = 4'd8;
`endif

    logic       rxdMeta_q;
    logic       rxdSync_q;
    logic       bclkx8_q;
    logic       tick;
    state_t     state_q;
    logic [2:0] ct1_q;
    logic [3:0] ct2_q;
    logic [7:0] rsr_q;
    logic [7:0] rsrShift_d;
    logic       armed_q;
    logic [7:0] rdr_q;
    logic       rdrf_q;
    logic       oe_q;
    logic       fe_q;
`ifdef UART_RX_PARITY_EN
    logic       pe_q;
    logic       parErr_q;
`endif

    // Two-flop synchronizer for the line plus a delayed baud level for edge detection.
    // Everything resets high so an idle line and a high baud level produce no tick at release.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
            bclkx8_q  <= 1'b1;
        end else begin
            rxdMeta_q <= rxd;
            rxdSync_q <= rxdMeta_q;
            bclkx8_q  <= bclkx8;
        end
    end

    // One-cycle tick on each rising edge of the 8x baud level, and the next shift value.
    always_comb begin
        tick       = bclkx8 & ~bclkx8_q;
        rsrShift_d = {rxdSync_q, rsr_q[7:1]};
    end

    // Receive FSM with counters, shift register and host-visible holding register and flags.
    // The host clear is applied first so that a frame load in the same cycle overrides it.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ct1_q    <= 3'd0;
            ct2_q    <= 4'd0;
            rsr_q    <= 8'h00;
            armed_q  <= 1'b1;
            rdr_q    <= 8'h00;
            rdrf_q   <= 1'b0;
            oe_q     <= 1'b0;
            fe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q     <= 1'b0;
            parErr_q <= 1'b0;
`endif
        end else begin
            if (rdrf_clr) begin
                rdrf_q <= 1'b0;
                oe_q   <= 1'b0;
                fe_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                pe_q   <= 1'b0;
`endif
            end
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        if (rxdSync_q) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            ct1_q   <= 3'd0;
                            state_q <= START_DET;
                        end
                    end
                    START_DET: begin
                        if (rxdSync_q) begin
                            state_q <= IDLE;
                        end else if (ct1_q == 3'd3) begin
                            ct1_q   <= 3'd0;
                            state_q <= RECV_DATA;
                        end else begin
                            ct1_q <= ct1_q + 3'd1;
                        end
                    end
                    RECV_DATA: begin
                        if (ct1_q == 3'd7) begin
                            ct1_q <= 3'd0;
                            if (ct2_q < 4'd8) begin
                                rsr_q <= rsrShift_d;
                                ct2_q <= ct2_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                            end else if (ct2_q < STOP_CT) begin
                                parErr_q <= ^{rsr_q, rxdSync_q};
                                ct2_q    <= ct2_q + 4'd1;
`endif
                            end else begin
                                rdr_q   <= rsr_q;
                                rdrf_q  <= 1'b1;
                                oe_q    <= rdrf_q & ~rdrf_clr;
                                fe_q    <= ~rxdSync_q;
`ifdef UART_RX_PARITY_EN
                                pe_q    <= parErr_q;
`endif
                                armed_q <= rxdSync_q;
                                ct2_q   <= 4'd0;
                                state_q <= IDLE;
                            end
                        end else begin
                            ct1_q <= ct1_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign RDR  = rdr_q;
    assign RDRF = rdrf_q;
    assign OE   = oe_q;
    assign FE   = fe_q;
`ifdef UART_RX_PARITY_EN
    assign PE   = pe_q;
`else
    assign PE   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver.
// The baud level pulses high for one sysclk cycle in every four, so one bit lasts 32 cycles.
// Frames are started on a fixed tick phase so the stop-bit load cycle is known exactly.

module tb_uart_receiver;

    logic       sysclk;
    logic       rst;
    logic       rxd;
    logic       bclkx8;
    logic       rdrf_clr;
    logic [7:0] RDR;
    logic       RDRF;
    logic       OE;
    logic       FE;
    logic       PE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam int BIT_CYC = 32;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // First low sample is 3 cycles after the start edge, the stop sample 76 ticks later.
    localparam int LOAD_AT = (FRAME_BITS - 1) * BIT_CYC + 19;

    uart_receiver dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .rxd      (rxd),
        .bclkx8   (bclkx8),
        .rdrf_clr (rdrf_clr),
        .RDR      (RDR),
        .RDRF     (RDRF),
        .OE       (OE),
        .FE       (FE),
        .PE       (PE)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Baud level: high for the cycle following every fourth falling edge.
    initial begin
        bclkx8 = 1'b0;
        forever begin
            @(negedge sysclk);
            cyc    = cyc + 1;
            bclkx8 = (cyc % 4 == 0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Returns just before the falling edge that sits one cycle after a baud pulse.
    task automatic alignTick();
        do @(posedge sysclk); while (cyc % 4 != 0);
    endtask

    task automatic holdLine(input logic val, input int ncyc);
        @(negedge sysclk);
        rxd = val;
        repeat (ncyc) @(negedge sysclk);
    endtask

    task automatic pulseClear();
        @(negedge sysclk);
        rdrf_clr = 1'b1;
        @(negedge sysclk);
        rdrf_clr = 1'b0;
    endtask

    // Sends one frame; clrAt pulses rdrf_clr on that cycle, abortAt asserts rst and stops.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parFlip,
                                 input int clrAt, input int abortAt);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^data) ^ parFlip;
        bits[10]  = stopBit;
`else
        bits[9]   = stopBit;
        bits[10]  = parFlip | 1'b1;
`endif
        alignTick();
        for (int i = 0; i < FRAME_BITS * BIT_CYC; i++) begin
            @(negedge sysclk);
            if (i == abortAt) begin
                rst = 1'b1;
                break;
            end
            if (i % BIT_CYC == 0) rxd = bits[i / BIT_CYC];
            rdrf_clr = (i == clrAt);
        end
        rdrf_clr = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rxd      = 1'b1;
        rdrf_clr = 1'b0;
        repeat (3) @(negedge sysclk);
        checkOutput("rst_rdr",  RDR,  8'h00);
        checkOutput("rst_rdrf", {7'd0, RDRF}, 8'd0);
        checkOutput("rst_oe",   {7'd0, OE},   8'd0);
        checkOutput("rst_fe",   {7'd0, FE},   8'd0);
        checkOutput("rst_pe",   {7'd0, PE},   8'd0);
        @(negedge sysclk);
        rst = 1'b0;
        holdLine(1'b1, 40);

        // Single clean frame, then a host read.
        applyStimulus(8'hA5, 1'b1, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("a5_rdr",  RDR,  8'hA5);
        checkOutput("a5_rdrf", {7'd0, RDRF}, 8'd1);
        checkOutput("a5_oe",   {7'd0, OE},   8'd0);
        checkOutput("a5_fe",   {7'd0, FE},   8'd0);
        checkOutput("a5_pe",   {7'd0, PE},   8'd0);
        rdrf_clr = 1'b1;
        checkOutput("clr_rdrf_before", {7'd0, RDRF}, 8'd1);
        @(negedge sysclk);
        rdrf_clr = 1'b0;
        checkOutput("clr_rdrf_after", {7'd0, RDRF}, 8'd0);

        // Two-tick low glitch must not start a frame.
        alignTick();
        @(negedge sysclk);
        rxd = 1'b0;
        repeat (8) @(negedge sysclk);
        rxd = 1'b1;
        holdLine(1'b1, 400);
        checkOutput("glitch_rdrf", {7'd0, RDRF}, 8'd0);
        applyStimulus(8'h3C, 1'b1, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("3c_rdr",  RDR,  8'h3C);
        checkOutput("3c_rdrf", {7'd0, RDRF}, 8'd1);
        pulseClear();

        // Back-to-back frames with no read in between.
        applyStimulus(8'h11, 1'b1, 1'b0, -1, -1);
        applyStimulus(8'h22, 1'b1, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("b2b_rdr",  RDR,  8'h22);
        checkOutput("b2b_rdrf", {7'd0, RDRF}, 8'd1);
        checkOutput("b2b_oe",   {7'd0, OE},   8'd1);
        checkOutput("b2b_fe",   {7'd0, FE},   8'd0);
        pulseClear();

        // Framing error followed by a long break: exactly one load.
        applyStimulus(8'h55, 1'b0, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("brk_rdr",  RDR,  8'h55);
        checkOutput("brk_fe",   {7'd0, FE},   8'd1);
        checkOutput("brk_rdrf", {7'd0, RDRF}, 8'd1);
        pulseClear();
        holdLine(1'b0, 30 * BIT_CYC);
        checkOutput("brk_no_reload", {7'd0, RDRF}, 8'd0);
        holdLine(1'b1, 64);
        applyStimulus(8'h66, 1'b1, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("rearm_rdr", RDR, 8'h66);
        checkOutput("rearm_fe",  {7'd0, FE}, 8'd0);
        pulseClear();

        // Host clear on the exact load cycle of a second unread frame.
        applyStimulus(8'h33, 1'b1, 1'b0, -1, -1);
        applyStimulus(8'h44, 1'b1, 1'b0, LOAD_AT, -1);
        @(negedge sysclk);
        checkOutput("clrload_rdrf", {7'd0, RDRF}, 8'd1);
        checkOutput("clrload_oe",   {7'd0, OE},   8'd0);
        checkOutput("clrload_rdr",  RDR,  8'h44);

        // Reset after four data bits, then a full frame.
        applyStimulus(8'h0F, 1'b1, 1'b0, -1, 5 * BIT_CYC + 16);
        @(negedge sysclk);
        checkOutput("abort_rdr",  RDR,  8'h00);
        checkOutput("abort_rdrf", {7'd0, RDRF}, 8'd0);
        checkOutput("abort_oe",   {7'd0, OE},   8'd0);
        checkOutput("abort_fe",   {7'd0, FE},   8'd0);
        checkOutput("abort_pe",   {7'd0, PE},   8'd0);
        rxd = 1'b1;
        repeat (4) @(negedge sysclk);
        rst = 1'b0;
        holdLine(1'b1, 64);
        applyStimulus(8'h7E, 1'b1, 1'b0, -1, -1);
        @(negedge sysclk);
        checkOutput("7e_rdr",  RDR,  8'h7E);
        checkOutput("7e_fe",   {7'd0, FE},   8'd0);
        checkOutput("7e_rdrf", {7'd0, RDRF}, 8'd1);
        checkOutput("7e_pe",   {7'd0, PE},   8'd0);
`ifdef UART_RX_PARITY_EN
        pulseClear();
        applyStimulus(8'h7E, 1'b1, 1'b1, -1, -1);
        @(negedge sysclk);
        checkOutput("7e_odd_pe",  {7'd0, PE}, 8'd1);
        checkOutput("7e_odd_rdr", RDR, 8'h7E);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
